// File: rtl/keypad_pkg.sv
// Shared constants, state encodings and key lookup for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } db_state_t;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_ONE   = 2'd1,
    FR_MULTI = 2'd2
  } frame_class_t;

  // Row-major matrix position (row*4+col) to hex code; '*' maps to E, '#' to F.
  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad column inputs; idles at all-ones.
module sync2
  import keypad_pkg::*;
#(
  parameter int WIDTH = NUM_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobing, whole-frame debounce and a valid/ack key output.
//
// state         | meaning
// ST_RELEASED   | no key down, waiting for a single-key frame
// ST_PRESS_DB   | candidate key seen, counting identical frames
// ST_PRESSED    | key accepted and held
// ST_RELEASE_DB | empty frames seen after a press, counting toward release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1024,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int SW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam bit            SINGLE     = (DEBOUNCE_SCANS <= 1);

  logic [3:0]          col_s;
  logic [SW-1:0]       slot_cnt;
  logic [1:0]          row_idx;
  logic [NUM_KEYS-1:0] frame;
  logic                eval;
  logic                slot_last;

  logic [4:0]          low_cnt;
  logic [3:0]          low_idx;
  frame_class_t        fr_class;

  db_state_t           state, state_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_inc;
  logic [3:0]          cand, cand_n;
  logic                accept;

  sync2 #(.WIDTH(NUM_COLS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col),
    .q     (col_s)
  );

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign row       = ~(4'b0001 << row_idx);

  // Each row's columns are captured at the end of its slot; the frame is
  // evaluated one cycle after the last row lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      frame    <= '1;
      eval     <= 1'b0;
    end else begin
      eval <= slot_last && (row_idx == 2'(NUM_ROWS - 1));
      if (slot_last) begin
        slot_cnt                          <= '0;
        row_idx                           <= row_idx + 2'd1;
        frame[{row_idx, 2'b00} +: NUM_COLS] <= col_s;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!frame[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    if (low_cnt == 5'd0)      fr_class = FR_NONE;
    else if (low_cnt == 5'd1) fr_class = FR_ONE;
    else                      fr_class = FR_MULTI;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RELEASED;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (eval) begin
      if (fr_class == FR_MULTI) begin
        cnt_n = '0;
      end else begin
        case (state)
          ST_RELEASED: begin
            if (fr_class == FR_ONE) begin
              cand_n = low_idx;
              cnt_n  = CW'(1);
              if (SINGLE) begin
                accept  = 1'b1;
                state_n = ST_PRESSED;
                cnt_n   = '0;
              end else begin
                state_n = ST_PRESS_DB;
              end
            end
          end
          ST_PRESS_DB: begin
            if (fr_class == FR_NONE) begin
              state_n = ST_RELEASED;
              cnt_n   = '0;
            end else if (low_idx == cand) begin
              cnt_n = cnt_inc;
              if (cnt_inc >= CNT_TARGET) begin
                accept  = 1'b1;
                state_n = ST_PRESSED;
                cnt_n   = '0;
              end
            end else begin
              cand_n = low_idx;
              cnt_n  = CW'(1);
            end
          end
          ST_PRESSED: begin
            if (fr_class == FR_NONE) begin
              cnt_n   = CW'(1);
              state_n = SINGLE ? ST_RELEASED : ST_RELEASE_DB;
            end
          end
          default: begin
            if (fr_class == FR_ONE) begin
              state_n = ST_PRESSED;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
              if (cnt_inc >= CNT_TARGET) begin
                state_n = ST_RELEASED;
                cnt_n   = '0;
              end
            end
          end
        endcase
      end
    end
  end

  assign key_held = (state == ST_PRESSED) || (state == ST_RELEASE_DB);

  // An accept wins over an ack in the same cycle: the new code stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      key_code  <= key_lookup(cand_n);
      key_valid <= 1'b1;
      if (key_valid && !key_ack) overrun <= 1'b1;
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch-matrix model driving col from row.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ack;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int events = 0;
  int held_cnt = 0;
  logic kv_prev = 1'b0;

  always #5 clk = ~clk;

  // Closed switch at (r,c) pulls column c low while row r is strobed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (key_valid && !kv_prev) events++;
    kv_prev = key_valid;
    if (key_held) held_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle of a frame (row 0 just strobed).
  task automatic align_frame(input string tag);
    logic [3:0] prev;
    int n;
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 64) begin
      prev = row;
      @(negedge clk);
      n++;
      if (row == 4'b1110 && prev == 4'b0111) found = 1'b1;
    end
    if (!found) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_held(input logic level, input int budget, input string tag);
    int n;
    n = 0;
    while (key_held !== level && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, key_held, level);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  initial begin
    int n;
    int ev0;
    int h0;

    reset   = 1'b1;
    key_ack = 1'b0;
    keys    = '0;
    cyc(3);
    chk("rst_row", row, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;

    // 1: stable press of key 6
    ev0 = events;
    align_frame("t1_align");
    keys[6] = 1'b1;
    wait_valid(200, n);
    chk("t1_valid", key_valid, 1'b1);
    chk("t1_latency_in_range", (n >= 48 && n <= 67), 1'b1);
    chk("t1_code", key_code, 4'h6);
    chk("t1_held", key_held, 1'b1);
    ack_pulse();
    chk("t1_ack_clears", key_valid, 1'b0);
    cyc(80);
    chk("t1_single_event", events - ev0, 1);
    chk("t1_still_held", key_held, 1'b1);
    keys = '0;
    wait_held(1'b0, 200, "t1_release");

    // 2: bouncing key 0 then stable
    ev0 = events;
    align_frame("t2_align");
    for (int i = 0; i < 8; i++) begin
      keys[13] = ~keys[13];
      cyc(5);
    end
    keys[13] = 1'b1;
    cyc(96);
    chk("t2_single_event", events - ev0, 1);
    chk("t2_code", key_code, 4'h0);
    chk("t2_valid", key_valid, 1'b1);
    chk("t2_overrun", overrun, 1'b0);
    ack_pulse();
    keys = '0;
    wait_held(1'b0, 200, "t2_release");

    // 3: A then B without ack
    align_frame("t3_align_a");
    keys[3] = 1'b1;
    wait_valid(200, n);
    chk("t3_code_a", key_code, 4'hA);
    keys = '0;
    wait_held(1'b0, 200, "t3_release_a");
    align_frame("t3_align_b");
    keys[7] = 1'b1;
    n = 0;
    while (key_code !== 4'hB && n < 200) begin
      cyc(1);
      n++;
    end
    chk("t3_code_b", key_code, 4'hB);
    chk("t3_valid_b", key_valid, 1'b1);
    chk("t3_overrun", overrun, 1'b1);
    ack_pulse();
    chk("t3_ack_clears", key_valid, 1'b0);
    keys = '0;
    wait_held(1'b0, 200, "t3_release_b");

    // 4: two keys together
    ev0 = events;
    h0  = held_cnt;
    align_frame("t4_align");
    keys[0]  = 1'b1;
    keys[10] = 1'b1;
    cyc(160);
    chk("t4_no_event", events - ev0, 0);
    chk("t4_never_held", held_cnt - h0, 0);
    chk("t4_valid", key_valid, 1'b0);
    keys = '0;
    cyc(64);

    // 5: ack coincides with a new accept
    reset = 1'b1;
    cyc(2);
    chk("t5_rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    align_frame("t5_align_1");
    keys[0] = 1'b1;
    wait_valid(200, n);
    chk("t5_code_1", key_code, 4'h1);
    keys = '0;
    wait_held(1'b0, 200, "t5_release_1");
    align_frame("t5_align_2");
    keys[1] = 1'b1;
    cyc(48);
    chk("t5_pre_valid", key_valid, 1'b1);
    chk("t5_pre_code", key_code, 4'h1);
    ack_pulse();
    chk("t5_valid_kept", key_valid, 1'b1);
    chk("t5_code_new", key_code, 4'h2);
    chk("t5_no_overrun", overrun, 1'b0);
    keys = '0;
    wait_held(1'b0, 200, "t5_release_2");

    // 6: reset in PRESS_DB with cnt=2 (key 5 pressed, two frames evaluated)
    align_frame("t6_align");
    keys[5] = 1'b1;
    cyc(40);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6_row", row, 4'b1110);
    chk("t6_valid", key_valid, 1'b0);
    chk("t6_held", key_held, 1'b0);
    cyc(47);
    chk("t6_no_early_accept", key_valid, 1'b0);
    wait_valid(40, n);
    chk("t6_redebounced", key_valid, 1'b1);
    chk("t6_code", key_code, 4'h5);
    keys = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
